// File: rtl/k007232_mix_pkg.sv
// k007232_mix_pkg: shared types, widths and sample conversion for the 007232 volume mixer.
package k007232_mix_pkg;

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SUM, DCB} state_t;

    localparam int SMP_W  = 7;
    localparam int VOL_W  = 4;
    localparam int PROD_W = 11;

    function automatic logic signed [SMP_W-1:0] ofs2sgn(input logic [SMP_W-1:0] x);
        return {~x[SMP_W-1], x[SMP_W-2:0]};
    endfunction

endpackage

// File: rtl/k007232_mix_dcblock.sv
// k007232_mix_dcblock: one-pole DC blocker on the mixed sum, saturated to MIX_W.
module k007232_mix_dcblock #(
    parameter int MIX_W = 12
) (
    input  logic                    mclk,
    input  logic                    i_RST,
    input  logic                    i_en,
    input  logic signed [MIX_W-1:0] i_x,
    output logic signed [MIX_W-1:0] o_y
);
    localparam int ACC_W = MIX_W + 2;

    logic signed [MIX_W-1:0] x_prev;
    logic signed [ACC_W-1:0] y_prev, y;
    logic                    in_range;

    assign y        = ACC_W'(i_x) - ACC_W'(x_prev) + y_prev - (y_prev >>> 8);
    assign in_range = (&y[ACC_W-1:MIX_W-1]) || !(|y[ACC_W-1:MIX_W-1]);
    assign o_y      = in_range ? y[MIX_W-1:0] : {y[ACC_W-1], {(MIX_W-1){~y[ACC_W-1]}}};

    // History stays unsaturated so clipping never feeds back into the filter.
    always_ff @(posedge mclk) begin
        if (i_RST) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (i_en) begin
            x_prev <= i_x;
            y_prev <= y;
        end
    end

endmodule

// File: rtl/k007232_vol_mixer.sv
// k007232_vol_mixer: 007232 volume latch, shared-multiplier channel scaling and A+B mix.
// Define K007232_MIX_DCBLOCK_EN to pass o_MIX through a DC blocker (adds one cycle of latency).
module k007232_vol_mixer
    import k007232_mix_pkg::*;
#(
    parameter int MIX_W = 12,
    parameter int CH_W  = 11
) (
    input  logic                    mclk,
    input  logic                    i_RST,
    input  logic                    i_SMP_STB,
    input  logic                    i_SLEV_n,
    input  logic [7:0]              i_DB,
    input  logic [SMP_W-1:0]        i_ASD,
    input  logic [SMP_W-1:0]        i_BSD,
    output logic [VOL_W-1:0]        o_VOL_A,
    output logic [VOL_W-1:0]        o_VOL_B,
    output logic signed [CH_W-1:0]  o_SND_A,
    output logic signed [CH_W-1:0]  o_SND_B,
    output logic signed [MIX_W-1:0] o_MIX,
    output logic                    o_VALID,
    output logic                    o_BUSY,
    output logic                    o_OVR
);
    state_t                   state;
    logic                     slev_q;
    logic [7:0]               shadow;
    logic signed [SMP_W-1:0]  ws_a, ws_b, m_s;
    logic [VOL_W-1:0]         wv_a, wv_b, m_v;
    logic signed [PROD_W-1:0] pa, prod;
    logic signed [MIX_W-1:0]  raw_sum;

    assign m_s    = (state == MUL_A) ? ws_a : ws_b;
    assign m_v    = (state == MUL_A) ? wv_a : wv_b;
    assign prod   = PROD_W'(m_s) * PROD_W'($signed({1'b0, m_v}));
    assign o_BUSY = (state != IDLE);

`ifdef K007232_MIX_DCBLOCK_EN
    logic signed [PROD_W-1:0] pb;
    logic signed [MIX_W-1:0]  mix_f;

    assign raw_sum = MIX_W'(pa) + MIX_W'(pb);

    k007232_mix_dcblock #(.MIX_W(MIX_W)) u_dcb (
        .mclk  (mclk),
        .i_RST (i_RST),
        .i_en  (state == SUM),
        .i_x   (raw_sum),
        .o_y   (mix_f)
    );
`else
    assign raw_sum = MIX_W'(pa) + MIX_W'(prod);
`endif

    // Outputs are published on the edge entering the state that carries o_VALID.
    always_ff @(posedge mclk) begin
        if (i_RST) begin
            state   <= IDLE;
            slev_q  <= 1'b1;
            shadow  <= '0;
            o_VOL_A <= '0;
            o_VOL_B <= '0;
            ws_a    <= '0;
            ws_b    <= '0;
            wv_a    <= '0;
            wv_b    <= '0;
            pa      <= '0;
`ifdef K007232_MIX_DCBLOCK_EN
            pb      <= '0;
`endif
            o_SND_A <= '0;
            o_SND_B <= '0;
            o_MIX   <= '0;
            o_VALID <= 1'b0;
            o_OVR   <= 1'b0;
        end else begin
            slev_q  <= i_SLEV_n;
            o_VALID <= 1'b0;
            if (!i_SLEV_n) shadow <= i_DB;
            if (!slev_q && i_SLEV_n) begin
                o_VOL_A <= shadow[7:4];
                o_VOL_B <= shadow[3:0];
            end
            if (i_SMP_STB && state != IDLE) o_OVR <= 1'b1;
            case (state)
                IDLE: if (i_SMP_STB) begin
                    ws_a  <= ofs2sgn(i_ASD);
                    ws_b  <= ofs2sgn(i_BSD);
                    wv_a  <= o_VOL_A;
                    wv_b  <= o_VOL_B;
                    state <= MUL_A;
                end
                MUL_A: begin
                    pa    <= prod;
                    state <= MUL_B;
                end
`ifdef K007232_MIX_DCBLOCK_EN
                MUL_B: begin
                    pb    <= prod;
                    state <= SUM;
                end
                SUM: begin
                    o_SND_A <= CH_W'(pa);
                    o_SND_B <= CH_W'(pb);
                    o_MIX   <= mix_f;
                    o_VALID <= 1'b1;
                    state   <= DCB;
                end
`else
                MUL_B: begin
                    o_SND_A <= CH_W'(pa);
                    o_SND_B <= CH_W'(prod);
                    o_MIX   <= raw_sum;
                    o_VALID <= 1'b1;
                    state   <= SUM;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
